// File: rtl/alu_mdu.sv
// alu_mdu: execute-stage integer unit.
//   Single-cycle ALU (logic/add/sub/shift/min-max/branch compare) whose result
//   retires one cycle after issue, plus an iterative multiply/divide unit that
//   takes WIDTH cycles and stalls issue (ready_o low) while busy.
// Ports:
//   core_clock_i, core_reset_i (async, active high), flush_i
//   a_i, b_i, opc_i, dest_i, bank_i, valid_i -> issue; ready_o <- accept allowed
//   wb_valid_o, wb_reg_wen_o, wb_result_o, wb_dest_o, wb_bank_o,
//   wb_branch_exec_o, wb_branch_taken_o -> writeback
module alu_mdu #(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             core_clock_i,
  input  logic             core_reset_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [6:0]       opc_i,
  input  logic [4:0]       dest_i,
  input  logic             bank_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             wb_valid_o,
  output logic             wb_reg_wen_o,
  output logic [WIDTH-1:0] wb_result_o,
  output logic [4:0]       wb_dest_o,
  output logic             wb_bank_o,
  output logic             wb_branch_exec_o,
  output logic             wb_branch_taken_o
);

  // state  | meaning
  // S_IDLE | no MDU op in flight
  // S_BUSY | one multiply/divide iteration per cycle
  // S_DONE | result drives writeback this cycle; new issue allowed
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;

  localparam logic [6:0] OP_XOR  = 7'b0000000, OP_AND  = 7'b0001000, OP_OR   = 7'b0010000;
  localparam logic [6:0] OP_ADD  = 7'b0011000, OP_SUB  = 7'b0011001;
  localparam logic [6:0] OP_MINU = 7'b0100000, OP_MIN  = 7'b0100001;
  localparam logic [6:0] OP_MAXU = 7'b0100010, OP_MAX  = 7'b0100011;
  localparam logic [6:0] OP_LSR  = 7'b0101000, OP_LSL  = 7'b0101001, OP_ASR  = 7'b0101010;
  localparam logic [6:0] OP_BEQ  = 7'b1000100, OP_BNE  = 7'b1000110, OP_BLT  = 7'b1000011;
  localparam logic [6:0] OP_BGE  = 7'b1000001, OP_BLTU = 7'b1000010, OP_BGEU = 7'b1000000;

  state_t                 state_q, state_d;
  logic [SHW-1:0]         cnt_q, cnt_d;
  logic [2*WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]       opnd_q, opnd_d;
  logic [2:0]             mop_q, mop_d;
  logic                   qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;
  logic [4:0]             mdest_q, mdest_d;
  logic                   mbank_q, mbank_d;
  logic                   wb_valid_q, wb_valid_d, wb_wen_q, wb_wen_d;
  logic [WIDTH-1:0]       wb_result_q, wb_result_d;
  logic [4:0]             wb_dest_q, wb_dest_d;
  logic                   wb_bank_q, wb_bank_d, wb_bx_q, wb_bx_d, wb_bt_q, wb_bt_d;

  logic                   accept, is_mdu, mdu_start, mdu_retire;
  logic                   signed_op, a_neg, b_neg;
  logic [WIDTH-1:0]       a_mag, b_mag;
  logic [WIDTH-1:0]       sc_res;
  logic                   sc_listed, sc_wen, sc_bx, sc_bt, lt_s, lt_u;
  logic [SHW-1:0]         sh;
  logic [WIDTH:0]         mul_sum, div_rsh, div_diff;
  logic [2*WIDTH-1:0]     mul_step, div_step, prod;
  logic [WIDTH-1:0]       quo, rem, mdu_res;

  assign ready_o    = (state_q != S_BUSY);
  assign accept     = valid_i && ready_o && !flush_i;
  assign is_mdu     = (opc_i[6:3] == 4'b0110) && (opc_i[2:0] != 3'b011);
  assign mdu_start  = accept && is_mdu;
  assign mdu_retire = (state_q == S_DONE) && !flush_i;

  // mulh, div and rem work on magnitudes; signs are reapplied in S_DONE.
  assign signed_op = (opc_i[2:0] == 3'b001) || (opc_i[2:0] == 3'b100) || (opc_i[2:0] == 3'b110);
  assign a_neg     = signed_op && a_i[WIDTH-1];
  assign b_neg     = signed_op && b_i[WIDTH-1];
  assign a_mag     = a_neg ? -a_i : a_i;
  assign b_mag     = b_neg ? -b_i : b_i;

  always_comb begin
    sc_res    = '0;
    sc_listed = 1'b1;
    sc_bx     = 1'b0;
    sc_bt     = 1'b0;
    sh        = b_i[SHW-1:0];
    lt_s      = $signed(a_i) < $signed(b_i);
    lt_u      = a_i < b_i;
    case (opc_i)
      OP_XOR:  sc_res = a_i ^ b_i;
      OP_AND:  sc_res = a_i & b_i;
      OP_OR:   sc_res = a_i | b_i;
      OP_ADD:  sc_res = a_i + b_i;
      OP_SUB:  sc_res = a_i - b_i;
      OP_MINU: sc_res = lt_u ? a_i : b_i;
      OP_MIN:  sc_res = lt_s ? a_i : b_i;
      OP_MAXU: sc_res = lt_u ? b_i : a_i;
      OP_MAX:  sc_res = lt_s ? b_i : a_i;
      OP_LSR:  sc_res = a_i >> sh;
      OP_LSL:  sc_res = a_i << sh;
      OP_ASR:  sc_res = $unsigned($signed(a_i) >>> sh);
      OP_BEQ:  begin sc_bx = 1'b1; sc_bt = (a_i == b_i); end
      OP_BNE:  begin sc_bx = 1'b1; sc_bt = (a_i != b_i); end
      OP_BLT:  begin sc_bx = 1'b1; sc_bt = lt_s;  end
      OP_BGE:  begin sc_bx = 1'b1; sc_bt = !lt_s; end
      OP_BLTU: begin sc_bx = 1'b1; sc_bt = lt_u;  end
      OP_BGEU: begin sc_bx = 1'b1; sc_bt = !lt_u; end
      default: sc_listed = 1'b0;
    endcase
    sc_wen = sc_listed && !sc_bx && (dest_i != 5'd0);
  end

  // Multiply: acc = {partial high, remaining multiplier bits}, shift right each step.
  // Divide: acc = {partial remainder, remaining dividend / quotient bits}, shift left.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    mul_step = {mul_sum, acc_q[WIDTH-1:1]};
    div_rsh  = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff = div_rsh - {1'b0, opnd_q};
    div_step = div_diff[WIDTH] ? {div_rsh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                               : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    prod     = qneg_q ? -acc_q : acc_q;
    quo      = acc_q[WIDTH-1:0];
    rem      = acc_q[2*WIDTH-1:WIDTH];
    case (mop_q)
      3'b000:          mdu_res = prod[WIDTH-1:0];
      3'b001, 3'b010:  mdu_res = prod[2*WIDTH-1:WIDTH];
      // Divide by zero keeps the all-ones quotient regardless of operand signs.
      3'b100, 3'b101:  mdu_res = (qneg_q && !dz_q) ? -quo : quo;
      default:         mdu_res = rneg_q ? -rem : rem;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    mop_d   = mop_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    mdest_d = mdest_q;
    mbank_d = mbank_q;
    case (state_q)
      S_IDLE: if (mdu_start) state_d = S_BUSY;
      S_BUSY: begin
        if (flush_i) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          acc_d = mop_q[2] ? div_step : mul_step;
          if (cnt_q == SHW'(WIDTH-1)) begin
            state_d = S_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_DONE:  state_d = mdu_start ? S_BUSY : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (mdu_start) begin
      acc_d   = {{WIDTH{1'b0}}, a_mag};
      opnd_d  = b_mag;
      mop_d   = opc_i[2:0];
      qneg_d  = a_neg ^ b_neg;
      rneg_d  = a_neg;
      dz_d    = (b_i == '0);
      mdest_d = dest_i;
      mbank_d = bank_i;
    end
  end

  // Writeback registers carry single-cycle results; an MDU result is driven
  // directly in S_DONE and then captured so result/dest/bank hold afterwards.
  always_comb begin
    wb_valid_d  = 1'b0;
    wb_wen_d    = 1'b0;
    wb_bx_d     = 1'b0;
    wb_bt_d     = 1'b0;
    wb_result_d = wb_result_q;
    wb_dest_d   = wb_dest_q;
    wb_bank_d   = wb_bank_q;
    if (mdu_retire) begin
      wb_result_d = mdu_res;
      wb_dest_d   = mdest_q;
      wb_bank_d   = mbank_q;
    end
    if (accept && !is_mdu) begin
      wb_valid_d  = 1'b1;
      wb_wen_d    = sc_wen;
      wb_bx_d     = sc_bx;
      wb_bt_d     = sc_bt;
      wb_result_d = sc_res;
      wb_dest_d   = dest_i;
      wb_bank_d   = bank_i;
    end
  end

  always_ff @(posedge core_clock_i or posedge core_reset_i) begin
    if (core_reset_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      opnd_q      <= '0;
      mop_q       <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      dz_q        <= 1'b0;
      mdest_q     <= '0;
      mbank_q     <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_wen_q    <= 1'b0;
      wb_result_q <= '0;
      wb_dest_q   <= '0;
      wb_bank_q   <= 1'b0;
      wb_bx_q     <= 1'b0;
      wb_bt_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      opnd_q      <= opnd_d;
      mop_q       <= mop_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      dz_q        <= dz_d;
      mdest_q     <= mdest_d;
      mbank_q     <= mbank_d;
      wb_valid_q  <= wb_valid_d;
      wb_wen_q    <= wb_wen_d;
      wb_result_q <= wb_result_d;
      wb_dest_q   <= wb_dest_d;
      wb_bank_q   <= wb_bank_d;
      wb_bx_q     <= wb_bx_d;
      wb_bt_q     <= wb_bt_d;
    end
  end

  assign wb_valid_o        = mdu_retire || wb_valid_q;
  assign wb_reg_wen_o      = mdu_retire ? (mdest_q != 5'd0) : wb_wen_q;
  assign wb_result_o       = mdu_retire ? mdu_res : wb_result_q;
  assign wb_dest_o         = mdu_retire ? mdest_q : wb_dest_q;
  assign wb_bank_o         = mdu_retire ? mbank_q : wb_bank_q;
  assign wb_branch_exec_o  = !mdu_retire && wb_bx_q;
  assign wb_branch_taken_o = !mdu_retire && wb_bt_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Testbench for alu_mdu: WIDTH=32 and WIDTH=16 instances, directed corner
// cases plus random streams, scoreboard queues checked by independent monitors.
module tb_alu_mdu;

  localparam logic [6:0] OP_XOR = 7'b0000000, OP_ADD = 7'b0011000, OP_MIN = 7'b0100001;
  localparam logic [6:0] OP_MINU = 7'b0100000, OP_LSL = 7'b0101001, OP_ASR = 7'b0101010;
  localparam logic [6:0] OP_BLT = 7'b1000011, OP_BGEU = 7'b1000000;
  localparam logic [6:0] OP_MUL = 7'b0110000, OP_MULH = 7'b0110001, OP_MULHU = 7'b0110010;
  localparam logic [6:0] OP_DIV = 7'b0110100, OP_DIVU = 7'b0110101, OP_REM = 7'b0110110;

  logic [6:0] ops [0:24] = '{
    7'b0000000, 7'b0001000, 7'b0010000, 7'b0011000, 7'b0011001,
    7'b0100000, 7'b0100001, 7'b0100010, 7'b0100011,
    7'b0101000, 7'b0101001, 7'b0101010,
    7'b1000100, 7'b1000110, 7'b1000011, 7'b1000001, 7'b1000010, 7'b1000000,
    7'b0110000, 7'b0110001, 7'b0110010, 7'b0110100, 7'b0110101, 7'b0110110, 7'b0110111};

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        f32, v32, bank32, rdy32, wv32, wen32, wbk32, bx32, bt32;
  logic [31:0] a32, b32, res32;
  logic [6:0]  opc32;
  logic [4:0]  dest32, wd32;
  logic        f16, v16, bank16, rdy16, wv16, wen16, wbk16, bx16, bt16;
  logic [15:0] a16, b16, res16;
  logic [6:0]  opc16;
  logic [4:0]  dest16, wd16;

  alu_mdu #(.WIDTH(32)) u_dut32 (
    .core_clock_i(clk), .core_reset_i(rst), .flush_i(f32), .a_i(a32), .b_i(b32),
    .opc_i(opc32), .dest_i(dest32), .bank_i(bank32), .valid_i(v32), .ready_o(rdy32),
    .wb_valid_o(wv32), .wb_reg_wen_o(wen32), .wb_result_o(res32), .wb_dest_o(wd32),
    .wb_bank_o(wbk32), .wb_branch_exec_o(bx32), .wb_branch_taken_o(bt32));

  alu_mdu #(.WIDTH(16)) u_dut16 (
    .core_clock_i(clk), .core_reset_i(rst), .flush_i(f16), .a_i(a16), .b_i(b16),
    .opc_i(opc16), .dest_i(dest16), .bank_i(bank16), .valid_i(v16), .ready_o(rdy16),
    .wb_valid_o(wv16), .wb_reg_wen_o(wen16), .wb_result_o(res16), .wb_dest_o(wd16),
    .wb_bank_o(wbk16), .wb_branch_exec_o(bx16), .wb_branch_taken_o(bt16));

  typedef struct {
    logic [31:0] res;
    logic [4:0]  dest;
    logic        bank, wen, bx, bt;
    int          cyc;
  } exp_t;

  exp_t q32[$], q16[$];
  exp_t e32, e16;
  int checks = 0, fails = 0;

  function automatic void cmp(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic bit is_mdu(logic [6:0] opc);
    return opc inside {7'b0110000, 7'b0110001, 7'b0110010, 7'b0110100,
                       7'b0110101, 7'b0110110, 7'b0110111};
  endfunction

  // Reference model: plain integer arithmetic on w-bit values.
  function automatic exp_t model(int w, logic [31:0] a, logic [31:0] b, logic [6:0] opc,
                                 logic [4:0] dest, logic bank);
    exp_t e;
    longint unsigned ua, ub, mask, r;
    longint sa, sb, minv;
    int sh;
    mask = (64'd1 << w) - 64'd1;
    ua   = {32'd0, a} & mask;
    ub   = {32'd0, b} & mask;
    sa   = ua[w-1] ? $signed(ua) - $signed(64'd1 << w) : $signed(ua);
    sb   = ub[w-1] ? $signed(ub) - $signed(64'd1 << w) : $signed(ub);
    minv = -$signed(64'd1 << (w - 1));
    sh   = int'(ub % 64'(w));
    e.bx = 1'b0; e.bt = 1'b0; e.wen = (dest != 5'd0); r = 64'd0;
    case (opc)
      7'b0000000: r = ua ^ ub;
      7'b0001000: r = ua & ub;
      7'b0010000: r = ua | ub;
      7'b0011000: r = ua + ub;
      7'b0011001: r = ua - ub;
      7'b0100000: r = (ua < ub) ? ua : ub;
      7'b0100001: r = (sa < sb) ? ua : ub;
      7'b0100010: r = (ua > ub) ? ua : ub;
      7'b0100011: r = (sa > sb) ? ua : ub;
      7'b0101000: r = ua >> sh;
      7'b0101001: r = ua << sh;
      7'b0101010: r = $unsigned(sa >>> sh);
      7'b1000100: begin e.bx = 1'b1; e.bt = (ua == ub); end
      7'b1000110: begin e.bx = 1'b1; e.bt = (ua != ub); end
      7'b1000011: begin e.bx = 1'b1; e.bt = (sa < sb);  end
      7'b1000001: begin e.bx = 1'b1; e.bt = (sa >= sb); end
      7'b1000010: begin e.bx = 1'b1; e.bt = (ua < ub);  end
      7'b1000000: begin e.bx = 1'b1; e.bt = (ua >= ub); end
      7'b0110000: r = ua * ub;
      7'b0110001: r = $unsigned((sa * sb) >>> w);
      7'b0110010: r = (ua * ub) >> w;
      7'b0110100: r = (ub == 0) ? mask : ((sa == minv && sb == -1) ? ua : $unsigned(sa / sb));
      7'b0110101: r = (ub == 0) ? mask : ua / ub;
      7'b0110110: r = (ub == 0) ? ua : ((sa == minv && sb == -1) ? 64'd0 : $unsigned(sa % sb));
      7'b0110111: r = (ub == 0) ? ua : ua % ub;
      default:    e.wen = 1'b0;
    endcase
    if (e.bx) e.wen = 1'b0;
    e.res  = 32'(r & mask);
    e.dest = dest;
    e.bank = bank;
    e.cyc  = 0;
    return e;
  endfunction

  function automatic logic rdy(int w);
    return (w == 32) ? rdy32 : rdy16;
  endfunction

  function automatic logic [31:0] rnd_opnd(int w);
    case ($urandom_range(5))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'd1 << (w - 1);
      4:       return 32'($urandom_range(15));
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [6:0] pick_op();
    if ($urandom_range(15) == 0) return 7'($urandom_range(127));
    return ops[$urandom_range(24)];
  endfunction

  // Called just after a rising edge; the op is accepted at the next edge.
  task automatic issue(int w, logic [6:0] opc, logic [31:0] a, logic [31:0] b,
                       logic [4:0] dest, logic bank, logic flush);
    exp_t e;
    if (w == 32) begin
      v32 = 1'b1; opc32 = opc; a32 = a; b32 = b; dest32 = dest; bank32 = bank; f32 = flush;
    end else begin
      v16 = 1'b1; opc16 = opc; a16 = a[15:0]; b16 = b[15:0]; dest16 = dest; bank16 = bank; f16 = flush;
    end
    e = model(w, a, b, opc, dest, bank);
    e.cyc = cyc + (is_mdu(opc) ? w + 1 : 1);
    if (!flush) begin
      if (w == 32) q32.push_back(e); else q16.push_back(e);
    end
    @(posedge clk); #1;
    v32 = 1'b0; f32 = 1'b0; v16 = 1'b0; f16 = 1'b0;
    if (is_mdu(opc) && !flush) begin
      for (int i = 0; i < w; i++) begin
        cmp($sformatf("rdy%0d_busy", w), 64'(rdy(w)), 64'd0);
        @(posedge clk); #1;
      end
      cmp($sformatf("rdy%0d_done", w), 64'(rdy(w)), 64'd1);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (wv32) begin
        if (q32.size() == 0) cmp("w32_unexpected_wb", 64'(wv32), 64'd0);
        else begin
          e32 = q32.pop_front();
          cmp("w32_result", 64'(res32), 64'(e32.res));
          cmp("w32_wen", 64'(wen32), 64'(e32.wen));
          cmp("w32_dest", 64'({wbk32, wd32}), 64'({e32.bank, e32.dest}));
          cmp("w32_branch", 64'({bx32, bt32}), 64'({e32.bx, e32.bt}));
          cmp("w32_latency_cycle", 64'(cyc), 64'(e32.cyc));
        end
      end else cmp("w32_idle_flags", 64'({wen32, bx32, bt32}), 64'd0);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (wv16) begin
        if (q16.size() == 0) cmp("w16_unexpected_wb", 64'(wv16), 64'd0);
        else begin
          e16 = q16.pop_front();
          cmp("w16_result", 64'(res16), 64'(e16.res[15:0]));
          cmp("w16_wen", 64'(wen16), 64'(e16.wen));
          cmp("w16_dest", 64'({wbk16, wd16}), 64'({e16.bank, e16.dest}));
          cmp("w16_branch", 64'({bx16, bt16}), 64'({e16.bx, e16.bt}));
          cmp("w16_latency_cycle", 64'(cyc), 64'(e16.cyc));
        end
      end else cmp("w16_idle_flags", 64'({wen16, bx16, bt16}), 64'd0);
    end
  end

  task automatic check_reset_state();
    cmp("rst_wb_valid", 64'({wv32, wv16}), 64'd0);
    cmp("rst_wb_wen", 64'({wen32, wen16}), 64'd0);
    cmp("rst_wb_result", 64'({res32, res16}), 64'd0);
    cmp("rst_wb_dest_bank", 64'({wd32, wbk32, wd16, wbk16}), 64'd0);
    cmp("rst_wb_branch", 64'({bx32, bt32, bx16, bt16}), 64'd0);
    cmp("rst_ready", 64'({rdy32, rdy16}), 64'h3);
  endtask

  initial begin
    rst = 1'b1;
    {f32, v32, bank32, a32, b32, opc32, dest32} = '0;
    {f16, v16, bank16, a16, b16, opc16, dest16} = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state();
    rst = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of a multiply: no writeback may ever follow.
    v32 = 1'b1; opc32 = OP_MUL; a32 = 32'd9; b32 = 32'd9; dest32 = 5'd4;
    v16 = 1'b1; opc16 = OP_DIVU; a16 = 16'd99; b16 = 16'd7; dest16 = 5'd4;
    @(posedge clk); #1;
    v32 = 1'b0; v16 = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1 check_reset_state();
    @(posedge clk); #1;
    rst = 1'b0;

    issue(32, OP_ADD, 32'd5, 32'd7, 5'd1, 1'b0, 1'b0);
    issue(32, OP_ASR, 32'h8000_0000, 32'd4, 5'd2, 1'b1, 1'b0);
    issue(32, OP_LSL, 32'd1, 32'd31, 5'd2, 1'b0, 1'b0);
    issue(32, OP_MIN, 32'hFFFF_FFFF, 32'd1, 5'd5, 1'b0, 1'b0);
    issue(32, OP_MINU, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b0, 1'b0);
    issue(32, OP_BLT, 32'hFFFF_FFFF, 32'd0, 5'd3, 1'b0, 1'b0);
    issue(32, OP_BGEU, 32'd0, 32'd1, 5'd3, 1'b1, 1'b0);
    issue(32, OP_MUL, 32'hFFFF_FFFF, 32'd2, 5'd6, 1'b0, 1'b0);
    issue(32, OP_MULHU, 32'hFFFF_FFFF, 32'd2, 5'd7, 1'b1, 1'b0);
    issue(32, OP_MULH, 32'hFFFF_FFFF, 32'd2, 5'd8, 1'b0, 1'b0);
    issue(32, OP_DIV, 32'd7, 32'd0, 5'd9, 1'b0, 1'b0);
    issue(32, OP_REM, 32'd7, 32'd0, 5'd10, 1'b0, 1'b0);
    issue(32, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 1'b0, 1'b0);
    issue(32, OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 1'b0, 1'b0);
    issue(32, OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd12, 1'b1, 1'b0);
    issue(32, OP_XOR, 32'hA5A5_0000, 32'h0F0F_FFFF, 5'd13, 1'b0, 1'b0);

    // Flush on the issue cycle: nothing retires.
    issue(32, OP_ADD, 32'd3, 32'd4, 5'd14, 1'b0, 1'b1);
    @(posedge clk); #1;

    // divu 100/3 flushed at T+10; add 1+1 at T+11 retires at T+12.
    v32 = 1'b1; opc32 = OP_DIVU; a32 = 32'd100; b32 = 32'd3; dest32 = 5'd15;
    @(posedge clk); #1;
    v32 = 1'b0;
    repeat (9) @(posedge clk);
    #1 f32 = 1'b1;
    @(posedge clk); #1;
    f32 = 1'b0;
    cmp("flush_busy_ready", 64'(rdy32), 64'd1);
    issue(32, OP_ADD, 32'd1, 32'd1, 5'd16, 1'b0, 1'b0);
    repeat (40) @(posedge clk);
    #1;

    // Flush in the DONE cycle suppresses the multiply writeback.
    v32 = 1'b1; opc32 = OP_MUL; a32 = 32'd3; b32 = 32'd5; dest32 = 5'd17;
    @(posedge clk); #1;
    v32 = 1'b0;
    repeat (32) @(posedge clk);
    #1 f32 = 1'b1;
    #1 cmp("flush_done_wb_valid", 64'(wv32), 64'd0);
    @(posedge clk); #1;
    f32 = 1'b0;
    cmp("flush_done_ready", 64'(rdy32), 64'd1);

    for (int n = 0; n < 150; n++)
      issue(32, pick_op(), rnd_opnd(32), rnd_opnd(32), 5'($urandom_range(31)),
            1'($urandom_range(1)), 1'b0);

    issue(16, OP_MUL, 32'h0000_FFFF, 32'd2, 5'd1, 1'b0, 1'b0);
    issue(16, OP_DIV, 32'h0000_8000, 32'h0000_FFFF, 5'd2, 1'b1, 1'b0);
    issue(16, OP_REM, 32'h0000_FFF9, 32'd2, 5'd3, 1'b0, 1'b0);
    for (int n = 0; n < 80; n++)
      issue(16, pick_op(), rnd_opnd(16), rnd_opnd(16), 5'($urandom_range(31)),
            1'($urandom_range(1)), 1'b0);

    repeat (40) @(posedge clk);
    #1;
    cmp("q32_drained", 64'(q32.size()), 64'd0);
    cmp("q16_drained", 64'(q16.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
